// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter: one WIDTH-bit packet channel behind a
// registered output stage, grant held per packet and capped at MAX_BEATS beats.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_src,
  input  logic             out_ready,
  output logic [1:0]       grant,
  output logic             err
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_A = 2'd1,
    S_GNT_B = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_prio;        // 0 = A wins a tie, 1 = B wins a tie
  logic               w_prio_nxt;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_last;
  logic               r_out_src;
  logic               r_err;

  logic               w_space;
  logic               w_sel_b;
  logic               w_granted;
  logic               w_x_valid;
  logic [WIDTH-1:0]   w_x_data;
  logic               w_x_last;
  logic               w_accept;
  logic               w_force;
  logic               w_grant_end;
  logic               w_other_valid;

  // Select-driven 2:1 data path and handshake qualification
  assign w_space       = !r_out_valid || out_ready;
  assign w_sel_b       = (r_state == S_GNT_B);
  assign w_granted     = (r_state != S_IDLE);
  assign w_x_valid     = w_sel_b ? b_valid : a_valid;
  assign w_x_data      = w_sel_b ? b_data  : a_data;
  assign w_x_last      = w_sel_b ? b_last  : a_last;
  assign w_other_valid = w_sel_b ? a_valid : b_valid;

  assign a_ready = (r_state == S_GNT_A) && w_space;
  assign b_ready = (r_state == S_GNT_B) && w_space;

  assign w_accept    = w_granted && w_space && w_x_valid;
  assign w_cnt_inc   = r_beat_cnt + CNT_W'(1);
  assign w_force     = w_accept && (w_cnt_inc == MAX_CNT);
  assign w_grant_end = w_accept && (w_x_last || w_force);

  // Next grant; on grant end the pointer has already moved to the other side,
  // so a waiting other requester takes over with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;
    case (r_state)
      S_IDLE: begin
        if (a_valid && b_valid) w_state_nxt = r_prio ? S_GNT_B : S_GNT_A;
        else if (a_valid)       w_state_nxt = S_GNT_A;
        else if (b_valid)       w_state_nxt = S_GNT_B;
      end
      S_GNT_A, S_GNT_B: begin
        if (w_grant_end) begin
          w_prio_nxt = !w_sel_b;
          if (w_other_valid)  w_state_nxt = w_sel_b ? S_GNT_A : S_GNT_B;
          else if (w_x_valid) w_state_nxt = r_state;
          else                w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_beat_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_src   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
      r_err   <= w_force;
      if (w_grant_end)   r_beat_cnt <= '0;
      else if (w_accept) r_beat_cnt <= w_cnt_inc;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_x_data;
        r_out_last  <= w_x_last;
        r_out_src   <= w_sel_b;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_src   = r_out_src;
  assign err       = r_err;
  assign grant     = {r_state == S_GNT_B, r_state == S_GNT_A};

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: per-cycle behavioural model plus
// directed scenarios with literal expected beat sequences.
module tb_mux2_rr_arbiter;

  localparam int W    = 8;
  localparam int MAXB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_valid, a_last, a_ready;
  logic [W-1:0] a_data;
  logic         b_valid, b_last, b_ready;
  logic [W-1:0] b_data;
  logic         out_valid, out_last, out_src, out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   grant;
  logic         err;

  mux2_rr_arbiter #(.WIDTH(W), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready), .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask

  // Behavioural model: who owns the channel, whose turn a tie is, beats so far
  int           m_owner;   // 0 none, 1 A, 2 B
  int           m_turn;    // 1 A, 2 B
  int           m_beats;
  logic         m_ov, m_ol, m_os, m_err;
  logic [W-1:0] m_od;

  function automatic bit req_valid(int who);
    return (who == 1) ? a_valid : (who == 2) ? b_valid : 1'b0;
  endfunction

  always @(posedge clk) begin
    bit room, done, xl;
    logic [W-1:0] xd;
    int other;
    if (!rst_n) begin
      m_owner = 0; m_turn = 1; m_beats = 0;
      m_ov = 0; m_od = '0; m_ol = 0; m_os = 0; m_err = 0;
    end else begin
      room  = !m_ov || out_ready;
      done  = 0;
      m_err = 0;
      xl    = (m_owner == 2) ? b_last : a_last;
      xd    = (m_owner == 2) ? b_data : a_data;
      if (m_owner != 0 && room && req_valid(m_owner)) begin
        m_ov = 1; m_od = xd; m_ol = xl; m_os = (m_owner == 2);
        m_beats = m_beats + 1;
        if (m_beats == MAXB) m_err = 1;
        done = xl || (m_beats == MAXB);
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (m_owner == 0) begin
        if (a_valid && b_valid) m_owner = m_turn;
        else if (a_valid)       m_owner = 1;
        else if (b_valid)       m_owner = 2;
      end else if (done) begin
        other   = 3 - m_owner;
        m_turn  = other;
        m_beats = 0;
        if (req_valid(other))        m_owner = other;
        else if (!req_valid(m_owner)) m_owner = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] eg;
    bit eroom;
    if (cmp_en) begin
      eg    = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      eroom = !m_ov || out_ready;
      chk("grant",     grant,     eg);
      chk("out_valid", out_valid, m_ov);
      chk("out_data",  out_data,  m_od);
      chk("out_last",  out_last,  m_ol);
      chk("out_src",   out_src,   m_os);
      chk("err",       err,       m_err);
      chk("a_ready",   a_ready,   (m_owner == 1) && eroom);
      chk("b_ready",   b_ready,   (m_owner == 2) && eroom);
    end
  end

  // Delivered beats as {src, data}
  logic [8:0] log_q[$];
  logic [8:0] exp_q[$];

  always @(posedge clk)
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
      log_q.push_back({out_src, out_data});

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 0; a_last = 0; a_data = '0;
    b_valid = 0; b_last = 0; b_data = '0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    log_q.delete();
  endtask

  task automatic chk_log(string nm);
    chk({nm, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(nm, log_q[i], exp_q[i]);
  endtask

  initial begin
    int beat, k;
    bit acc;

    // Reset then idle
    do_reset();
    cmp_en = 1'b1;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_err", err, 1'b0);
    repeat (3) step();
    chk("idle_grant", grant, 2'b00);

    // Contention alternation with single-beat packets
    do_reset();
    a_valid = 1; a_data = 8'h11; a_last = 1;
    b_valid = 1; b_data = 8'h22; b_last = 1;
    step();
    #1 chk("alt_first_grant", grant, 2'b01);
    repeat (7) step();
    a_valid = 0; b_valid = 0;
    repeat (3) step();
    exp_q = '{9'h011, 9'h122, 9'h011, 9'h122, 9'h011, 9'h122, 9'h011};
    chk_log("alt_seq");

    // Packet lock: B waits for A's last
    do_reset();
    a_valid = 1; a_data = 8'h01; a_last = 0;
    step();
    step();
    a_data = 8'h02; b_valid = 1; b_data = 8'h44; b_last = 1;
    #1 chk("lock_b_ready1", b_ready, 1'b0);
    step();
    a_data = 8'h03; a_last = 1;
    #1 chk("lock_b_ready2", b_ready, 1'b0);
    step();
    a_valid = 0;
    #1 chk("lock_grant_b", grant, 2'b10);
    chk("lock_b_ready3", b_ready, 1'b1);
    step();
    b_valid = 0;
    repeat (2) step();
    exp_q = '{9'h001, 9'h002, 9'h003, 9'h144};
    chk_log("lock_seq");

    // Backpressure: three stalled cycles in the middle of a 5-beat packet
    do_reset();
    beat = 1; k = 0;
    a_valid = 1; a_data = 8'd1; a_last = 0;
    while (beat <= 5 && k < 40) begin
      out_ready = !(k >= 3 && k <= 5);
      @(negedge clk);
      acc = a_valid && a_ready;
      if (k >= 3 && k <= 5) begin
        chk("bp_hold_data", out_data, 8'h02);
        chk("bp_a_ready", a_ready, 1'b0);
      end
      step();
      if (acc) begin
        beat++;
        a_data = W'(beat);
        a_last = (beat == 5);
      end
      k++;
    end
    a_valid = 0; out_ready = 1;
    chk("bp_done", beat, 6);
    repeat (3) step();
    exp_q = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005};
    chk_log("bp_seq");

    // MAX_BEATS force-release while B waits
    do_reset();
    a_valid = 1; a_data = 8'h31; a_last = 0;
    b_valid = 1; b_data = 8'h55; b_last = 1;
    step();
    step(); a_data = 8'h32;
    step(); a_data = 8'h33;
    step(); a_data = 8'h34;
    step(); a_data = 8'h35;
    #1 chk("max_err_pulse", err, 1'b1);
    chk("max_grant_b", grant, 2'b10);
    chk("max_out_last", out_last, 1'b0);
    chk("max_out_data", out_data, 8'h34);
    step();
    b_valid = 0;
    #1 chk("max_err_clear", err, 1'b0);
    chk("max_grant_a", grant, 2'b01);
    step(); a_data = 8'h36;
    step(); a_valid = 0;
    repeat (2) step();
    exp_q = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h155, 9'h035, 9'h036};
    chk_log("max_seq");

    // Mid-packet reset after the pointer has moved to B
    do_reset();
    a_valid = 1; a_data = 8'h60; a_last = 1;
    step();
    step(); a_data = 8'h61; a_last = 0;
    step(); a_data = 8'h62; rst_n = 0;
    step();
    #1 chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_grant", grant, 2'b00);
    rst_n = 1; a_last = 1; b_valid = 1; b_data = 8'h77; b_last = 1;
    step();
    #1 chk("mrst_prio_a", grant, 2'b01);
    a_valid = 0; b_valid = 0;
    repeat (4) step();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Round-robin arbiter that shares one WIDTH-bit output channel between two requesters, A and B, using a select-driven 2:1 data path behind a registered output stage. Each requester sends multi-beat packets with a valid/ready/last handshake. A grant is held for a whole packet, and fairness alternates between requesters on contention. A MAX_BEATS counter stops a requester that never asserts last from holding the channel indefinitely.

## Interface
- WIDTH, 8: data width of each requester and of the output.
- MAX_BEATS, 16: maximum beats per grant (≥2); counter width is $clog2(MAX_BEATS+1).
- clk  input  1  clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- a_valid  input  1  requester A has a beat.
- a_data  input  WIDTH  requester A beat data.
- a_last  input  1  the current A beat ends its packet.
- a_ready  output  1  A beat accepted this cycle (combinational).
- b_valid, b_data, b_last, b_ready: as for A, for requester B.
- out_valid  output  1  registered output beat valid.
- out_data  output  WIDTH  registered output data.
- out_last  output  1  registered last flag.
- out_src  output  1  source of the output beat: 0 = A, 1 = B.
- out_ready  input  1  downstream accepts out_* this cycle.
- grant  output  2  current grant state, one-hot: 01 = A, 10 = B, 00 = idle.
- err  output  1  one-cycle pulse when a grant is force-released at MAX_BEATS.

## Operation
- States:
  - IDLE: grant = 00.
  - GNT_A: grant = 01; the data path selects a_*.
  - GNT_B: grant = 10; the data path selects b_*.
- Priority pointer `prio`: the requester that wins a tie. Reset value selects A. prio moves to the other requester whenever a grant ends.
- IDLE transitions:
  - Only a_valid → GNT_A.
  - Only b_valid → GNT_B.
  - Both valid → the state selected by prio.
  - Neither → stay in IDLE.
- Output-stage availability: `space` = !out_valid || out_ready.
- Ready generation: a_ready = (state == GNT_A) && space; b_ready = (state == GNT_B) && space. Ready is never asserted in IDLE.
- Beat acceptance (X = granted requester):
  - A beat is accepted when X_valid && X_ready.
  - On acceptance: out_data ← X_data, out_last ← X_last, out_src ← X, out_valid ← 1, and beat_cnt increments.
  - Else, if out_ready: out_valid ← 0.
- Grant end conditions:
  - An accepted beat with X_last = 1.
  - Or an accepted beat that makes beat_cnt = MAX_BEATS. In this case err pulses high for the next cycle, and out_last carries X_last unchanged.
- On grant end: beat_cnt ← 0 and prio ← other(X). The next state is evaluated in the same cycle with prio already updated:
  - Other requester valid → GNT_other (back-to-back, no bubble).
  - Else X_valid → GNT_X.
  - Else → IDLE.
- The grant is never revoked mid-packet for any reason other than MAX_BEATS. A requester dropping valid mid-packet keeps the grant.
- A downstream stall (out_ready = 0 with out_valid = 1) freezes out_* and deasserts X_ready. State and beat_cnt hold.
- Reset, in any state including mid-packet: state = IDLE, prio = A, beat_cnt = 0, out_valid = 0, out_data = 0, out_last = 0, out_src = 0, err = 0. Any partial packet is abandoned, with no flush.

## Timing
- Arbitration latency: 1 cycle. A request appearing in IDLE at edge N gives grant at edge N+1; X_ready can assert in the N+1 cycle.
- Data latency: a beat accepted at edge N is visible on out_* after edge N.
- Throughput: 1 beat per cycle while the granted requester is valid and out_ready = 1.
- Switching between packets on back-to-back contention costs 0 idle cycles.
- err is registered and pulses for exactly 1 cycle, in the cycle after the force-release acceptance.
- a_ready and b_ready depend combinationally on out_ready, out_valid and state. They never depend on a_valid or b_valid.

## Test plan
- Reset then idle: rst_n = 0 for 2 cycles → all outputs 0 and grant = 00. Release with no valids → grant stays 00.
- Contention alternation:
  - Stimulus: A and B both continuously send 1-beat packets (last = 1) with a_data = 8'h11 and b_data = 8'h22, out_ready = 1.
  - Required: grant 01 first. out_data sequence 11, 22, 11, 22, … with out_src 0, 1, 0, 1, and no bubbles after the first beat.
- Packet lock:
  - Stimulus: A sends a 3-beat packet (0x01, 0x02, 0x03 with last on 0x03); B raises valid at beat 2.
  - Required: out_data 01, 02, 03 from A, then B is granted. b_ready = 0 until A's last is accepted.
- Backpressure:
  - Stimulus: out_ready = 0 for 3 cycles while out_valid = 1.
  - Required: out_data is stable, a_ready = 0, and no beat is lost or duplicated after out_ready returns to 1.
- MAX_BEATS force-release:
  - Stimulus: MAX_BEATS = 4; A streams 6 beats without last while B is valid.
  - Required: after 4 A beats, err pulses for 1 cycle and grant switches to 10.
- Mid-packet reset:
  - Stimulus: assert rst_n = 0 during beat 2 of an A packet.
  - Required: on the next edge, out_valid = 0 and grant = 00. After release with both valid, A is granted first (prio reset).
